// File: rtl/fetch_pkg.sv
// Shared types for the prefetching fetch unit: FSM states, queue entry layout and fetch stride.
package fetch_pkg;

    localparam int FETCH_XLEN  = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_unit_if.sv
// Single-port BRAM read channel: the fetch unit drives enable/address, memory answers one cycle later.
interface ram_interface #(
    parameter int XLEN = 32
);
    logic            en_i_a;
    logic [XLEN-1:0] addr_i_a;
    logic [XLEN-1:0] data_o_a;

    modport master (
        output en_i_a,
        output addr_i_a,
        input  data_o_a
    );

    modport slave (
        input  en_i_a,
        input  addr_i_a,
        output data_o_a
    );
endinterface

// File: rtl/prefetch_unit_fifo.sv
// Instruction queue: DEPTH x fetch_entry_t ring buffer with simultaneous push/pop and a flush
// that wins over both.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o,
    output logic         empty_o
);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    fetch_entry_t  mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    // NOTE: every variable gets a default before the branches so no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/prefetch_unit.sv
// Prefetching instruction fetch unit: credit-limited BRAM reads feeding a DEPTH-entry queue,
// flushed on branch redirect. Optional PREFETCH_BYPASS_EN forwards a returning read when the queue is empty.
module prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             branch_taken_en_i,
    input  logic [XLEN-1:0]  next_pc_i,
    output logic             valid_o,
    output logic [XLEN-1:0]  instruction_o,
    output logic [XLEN-1:0]  pc_o,
    input  logic             ready_i,
    ram_interface.master     ram_if
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;
    localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic            pending_q;
    logic [XLEN-1:0] pending_pc_q;

    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic [CW-1:0]   count;
    logic            empty;
    logic            pop;
    logic            push;
    logic            issue;
    logic            ret_live;
    logic [SW-1:0]   credit_used;
    logic            unused_pc_bits;

    assign unused_pc_bits = &{1'b0, next_pc_i[1:0]};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (branch_taken_en_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .empty_o     (empty)
    );

    // A return is discarded if a redirect lands in the same cycle.
    assign ret_live = pending_q && !branch_taken_en_i;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = FETCH_XLEN'(pending_pc_q);
        push_entry.instr = FETCH_XLEN'(ram_if.data_o_a);
    end

`ifdef PREFETCH_BYPASS_EN
    logic bypass;

    assign bypass        = empty && pending_q;
    assign valid_o       = !empty || bypass;
    assign instruction_o = bypass ? ram_if.data_o_a : XLEN'(head.instr);
    assign pc_o          = bypass ? pending_pc_q    : XLEN'(head.pc);
    // A forwarded word taken by the consumer this cycle never enters the queue.
    assign push          = ret_live && !(bypass && ready_i);
`else
    assign valid_o       = !empty;
    assign instruction_o = XLEN'(head.instr);
    assign pc_o          = XLEN'(head.pc);
    assign push          = ret_live;
`endif

    assign pop = valid_o && ready_i;

    // Credits: queued entries plus the in-flight read, less the entry leaving this cycle.
    assign credit_used = SW'(count) + SW'(pending_q) - SW'(pop);

    // A read issued alongside a redirect would be killed anyway, so none is issued.
    assign issue = (state_q != IDLE) && !branch_taken_en_i && (credit_used < DEPTH_W);

    assign ram_if.en_i_a   = issue;
    assign ram_if.addr_i_a = pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
        end else begin
            pending_q <= issue;
            if (issue) begin
                pending_pc_q <= pc_q;
            end

            if (branch_taken_en_i) begin
                state_q <= REDIRECT;
                pc_q    <= {next_pc_i[XLEN-1:2], 2'b00};
            end else begin
                unique case (state_q)
                    IDLE:     state_q <= RUN;
                    RUN:      state_q <= RUN;
                    REDIRECT: state_q <= RUN;
                    default:  state_q <= IDLE;
                endcase
                if (issue) begin
                    pc_q <= pc_q + XLEN'(INSTR_BYTES);
                end
            end
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit with a 1-cycle BRAM model whose word at address a is a >> 2.
module tb_prefetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk_i;
    logic            rst_i;
    logic            branch_taken_en_i;
    logic [XLEN-1:0] next_pc_i;
    logic            valid_o;
    logic [XLEN-1:0] instruction_o;
    logic [XLEN-1:0] pc_o;
    logic            ready_i;

    int n_checks;
    int n_fail;
    int n_issue;

    ram_interface #(.XLEN(XLEN)) ram_if ();

    prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .branch_taken_en_i (branch_taken_en_i),
        .next_pc_i         (next_pc_i),
        .valid_o           (valid_o),
        .instruction_o     (instruction_o),
        .pc_o              (pc_o),
        .ready_i           (ready_i),
        .ram_if            (ram_if)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (ram_if.en_i_a) begin
            ram_if.data_o_a <= ram_if.addr_i_a >> 2;
        end
    end

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_issue <= 0;
        end else if (ram_if.en_i_a) begin
            n_issue <= n_issue + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_i             = 1'b0;
        ready_i           = 1'b1;
        branch_taken_en_i = 1'b0;
        next_pc_i         = '0;

        // Reset state and first stream with ready held high
        #1 rst_i = 1'b1;
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_en", 32'(ram_if.en_i_a), 32'd0);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        step();
        check("idle_valid", 32'(valid_o), 32'd0);
        check("first_issue_en", 32'(ram_if.en_i_a), 32'd1);
        check("first_issue_addr", ram_if.addr_i_a, 32'h0);
        step();
        check("edge2_valid", 32'(valid_o), 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("stream_valid", 32'(valid_o), 32'd1);
            check("stream_pc", pc_o, 32'(4 * i));
            check("stream_instr", instruction_o, 32'(i));
            step();
        end

        // Backpressure: issue stops at DEPTH credits, queue held in order
        ready_i = 1'b0;
        pulse_reset();
        repeat (12) step();
        check("bp_issue_count", 32'(n_issue), 32'd4);
        check("bp_en_stopped", 32'(ram_if.en_i_a), 32'd0);
        check("bp_hold_valid", 32'(valid_o), 32'd1);
        check("bp_hold_pc", pc_o, 32'h0);
        ready_i = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_drain_valid", 32'(valid_o), 32'd1);
            check("bp_drain_pc", pc_o, 32'(4 * i));
            check("bp_drain_instr", instruction_o, 32'(i));
            step();
        end

        // Redirect with 3 queued entries and a read in flight
        ready_i = 1'b0;
        pulse_reset();
        repeat (5) step();
        check("br1_pre_pc", pc_o, 32'h0);
        branch_taken_en_i = 1'b1;
        next_pc_i         = 32'h100;
        step();
        branch_taken_en_i = 1'b0;
        ready_i           = 1'b1;
        check("br1_gap0_valid", 32'(valid_o), 32'd0);
        step();
        check("br1_gap1_valid", 32'(valid_o), 32'd0);
        step();
        check("br1_tgt_valid", 32'(valid_o), 32'd1);
        check("br1_tgt_pc", pc_o, 32'h100);
        check("br1_tgt_instr", instruction_o, 32'h40);
        step();
        check("br1_next_pc", pc_o, 32'h104);
        check("br1_next_instr", instruction_o, 32'h41);

        // Redirect coincident with a handshake, misaligned target
        branch_taken_en_i = 1'b1;
        next_pc_i         = 32'h203;
        #1;
        check("br2_pre_handshake", 32'(valid_o && ready_i), 32'd1);
        step();
        branch_taken_en_i = 1'b0;
        check("br2_gap0_valid", 32'(valid_o), 32'd0);
        step();
        check("br2_gap1_valid", 32'(valid_o), 32'd0);
        step();
        check("br2_tgt_valid", 32'(valid_o), 32'd1);
        check("br2_tgt_pc", pc_o, 32'h200);
        check("br2_tgt_instr", instruction_o, 32'h80);

        // Back-to-back redirects: only the second target survives
        branch_taken_en_i = 1'b1;
        next_pc_i         = 32'h40;
        step();
        next_pc_i = 32'h80;
        check("br3_gap0_valid", 32'(valid_o), 32'd0);
        step();
        branch_taken_en_i = 1'b0;
        check("br3_gap1_valid", 32'(valid_o), 32'd0);
        step();
        check("br3_gap2_valid", 32'(valid_o), 32'd0);
        step();
        check("br3_tgt_pc", pc_o, 32'h80);
        check("br3_tgt_instr", instruction_o, 32'h20);
        step();
        check("br3_next_pc", pc_o, 32'h84);
        check("br3_next_instr", instruction_o, 32'h21);

        // Asynchronous reset mid-stream
        #3;
        check("arst_pre_en", 32'(ram_if.en_i_a), 32'd1);
        rst_i = 1'b1;
        #1;
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_en", 32'(ram_if.en_i_a), 32'd0);
        #1 rst_i = 1'b0;
        step();
        check("arst_idle_valid", 32'(valid_o), 32'd0);
        step();
        step();
        check("arst_restart_valid", 32'(valid_o), 32'd1);
        check("arst_restart_pc", pc_o, 32'h0);
        check("arst_restart_instr", instruction_o, 32'h0);
        step();
        check("arst_next_pc", pc_o, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prefetch_unit.md
Name: prefetch_unit

Overview:
- Parametrised successor to the single-register fetch stage: a prefetching instruction fetch unit with a DEPTH-entry instruction queue between the BRAM port and decode.
- Issues one read per cycle to a 1-cycle-latency BRAM and tracks in-flight reads with credits.
- Never drops or duplicates an instruction under backpressure.
- Flushes queue and in-flight read on a branch redirect; delivers {pc, instruction} pairs over a valid/ready handshake.

Parameters:
XLEN, 32, instruction and address width
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, first fetch address after reset

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
branch_taken_en_i  input  1  redirect request, single-cycle pulse
next_pc_i  input  XLEN  redirect target; bits [1:0] ignored (treated as 0)
valid_o  output  1  queue head valid
instruction_o  output  XLEN  head instruction
pc_o  output  XLEN  address of head instruction
ready_i  input  1  consumer accepts head when valid_o && ready_i
ram_if  modport  -  ram_interface.master; drives en_i_a, addr_i_a; samples data_o_a one cycle after issue

Behaviour:
- Reset (async, while rst_i=1):
  - fetch pc = RESET_PC; queue empty; pending = 0; state = IDLE.
  - valid_o = 0; ram_if.en_i_a = 0.
- States (fetch_state_t):
  - IDLE -> RUN on the first clock after reset release; no read issued in IDLE.
  - RUN -> REDIRECT when branch_taken_en_i = 1.
  - REDIRECT -> RUN after one cycle. If another branch arrives in REDIRECT, stay in REDIRECT with the new target.
- Issue rule:
  - Issue in RUN or REDIRECT when count + pending - pop < DEPTH, where pop = valid_o && ready_i.
  - Issue drives en_i_a = 1 and addr_i_a = fetch pc; then fetch pc += 4 (wraps mod 2^XLEN) and pending <= 1 with pending_pc = issued address.
  - When not issuing, en_i_a = 0 and fetch pc holds.
  - Sustains 1 instruction/cycle with ready_i held high.
- Return:
  - Cycle after an issue, data_o_a and pending_pc are pushed into the queue unless killed.
  - Push and pop in the same cycle are allowed at any occupancy; the credit rule guarantees push never hits a full queue.
- Redirect (branch_taken_en_i sampled at edge E0):
  - At E0: queue flushed (count = 0); pending read killed (return ignored); fetch pc = {next_pc_i[XLEN-1:2], 2'b00}.
  - First target read issued in the cycle after E0.
  - Branch coincident with a pop: handshake is ignored and the head is discarded by the flush.
  - Branch wins over every other event.
- Latency (no bypass):
  - Redirect: valid_o rises 2 edges after E0, with pc_o = target.
  - Reset release: first valid_o 3 edges after release (IDLE cycle included).
- Backpressure:
  - With ready_i = 0, issue stops once count + pending = DEPTH.
  - Queue contents are held stable and in order.
- Reset mid-operation: all state cleared immediately, including a pending read; its data is never pushed.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined:
  - When the queue is empty and a non-killed read returns, valid_o/instruction_o/pc_o come combinationally from data_o_a/pending_pc in the return cycle.
  - If accepted that cycle, the data is not pushed; otherwise it is pushed.
  - Redirect-to-valid latency becomes 1 edge after issue, i.e. valid in the cycle after E0 + 1.
- Undefined: all output comes from the queue head; latencies as stated above.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, RUN, REDIRECT}.
  - fetch_entry_t packed struct {pc, instr}, parametrised via XLEN constant.
  - INSTR_BYTES = 4.
- Sub-module fetch_fifo: synchronous DEPTH x fetch_entry_t FIFO with push, pop, flush, count, async reset.
- prefetch_unit holds the FSM, credit logic and redirect kill.

Test Plan:
- Reset release, ready_i = 1, memory word[i] = i -> valid_o first at edge 3; pc_o = 0,4,8,12... and instruction_o = 0,1,2,3 on consecutive cycles, no gaps.
- ready_i = 0 for 10 cycles after the first valid (DEPTH = 4) -> exactly 4 reads issued, then en_i_a = 0; on release, 0,4,8,12,16 delivered in order with no loss or duplicate.
- Branch to 0x100 while queue holds 3 entries and a read is pending -> valid_o = 0 for the next 2 cycles; next delivered pc_o = 0x100, no stale entry.
- Branch with next_pc_i = 0x203 coincident with valid_o && ready_i -> next pc_o = 0x200; old head never re-presented.
- Back-to-back branches to 0x40 then 0x80 on consecutive cycles -> only 0x80 stream appears.
- rst_i asserted asynchronously mid-stream -> valid_o and en_i_a drop without a clock edge; after release, stream restarts at RESET_PC.
